// File: rtl/fp16_accumulator_if.sv
// rtl/fp16_accumulator_if.sv - operand stream and frame result bundle for fp16_accumulator
interface fp16_accumulator_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_sub;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_nan;
  logic             out_inf;
  logic             out_len_ovf;

  modport master (
    output in_valid, in_data, in_sub, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_nan, out_inf, out_len_ovf
  );

  modport slave (
    input  in_valid, in_data, in_sub, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_nan, out_inf, out_len_ovf
  );
endinterface

// File: rtl/fp16_accumulator.sv
// rtl/fp16_accumulator.sv - framed fp16 running-sum accumulator around a combinational fpadder
module fpadder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] s
);
  logic        sb;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [40:0] xa, xb, mag;
  logic        rs;
  logic [5:0]  msb, shift;
  logic [10:0] keep;
  logic        rnd, stk;
  logic [15:0] tmp;

  // Every finite fp16 value is an exact integer multiple of 2^-24; 41 bits hold any sum exactly.
  function automatic logic [40:0] to_fixed(input logic [15:0] v);
    logic [4:0] sh;
    sh = (v[14:10] == 5'd0) ? 5'd0 : v[14:10] - 5'd1;
    return {30'd0, (v[14:10] != 5'd0), v[9:0]} << sh;
  endfunction

  always_comb begin
    sb    = b[15] ^ sub;
    a_nan = (&a[14:10]) && (|a[9:0]);
    b_nan = (&b[14:10]) && (|b[9:0]);
    a_inf = (&a[14:10]) && !(|a[9:0]);
    b_inf = (&b[14:10]) && !(|b[9:0]);
    xa    = to_fixed(a);
    xb    = to_fixed(b);
    if (a[15] == sb) begin
      mag = xa + xb;
      rs  = a[15];
    end else if (xa >= xb) begin
      mag = xa - xb;
      rs  = a[15];
    end else begin
      mag = xb - xa;
      rs  = sb;
    end
    if (mag == 41'd0) rs = a[15] & sb;

    msb = 6'd0;
    for (int i = 0; i < 41; i++) begin
      if (mag[i]) msb = 6'(i);
    end

    shift = 6'd0;
    keep  = 11'd0;
    rnd   = 1'b0;
    stk   = 1'b0;
    if (msb <= 6'd10) begin
      tmp = {5'd0, mag[10:0]};
    end else begin
      // Round to nearest even; the carry out of the mantissa bumps the exponent naturally.
      shift = msb - 6'd10;
      keep  = 11'(mag >> shift);
      rnd   = mag[shift - 6'd1];
      stk   = |(mag & ((41'd1 << (shift - 6'd1)) - 41'd1));
      tmp   = {msb - 6'd9, keep[9:0]} + {15'd0, rnd & (stk | keep[0])};
    end

    if (tmp[15:10] >= 6'd31) s = {rs, 15'h7C00};
    else                     s = {rs, tmp[14:0]};

    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != sb))) s = 16'h7E00;
    else if (a_inf)                                           s = a;
    else if (b_inf)                                           s = {sb, b[14:0]};
  end
endmodule

module fp16_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  fp16_accumulator_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             nan_q, nan_d;
  logic             ovf_q, ovf_d;
  logic             ready_q, ready_d;
  logic [15:0]      sum_q, sum_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;
  logic             onan_q, onan_d;
  logic             oinf_q, oinf_d;
  logic             oovf_q, oovf_d;

  logic [15:0]      add_s;
  logic             accept, step_nan, nan_now, sat, ovf_now;
  logic [15:0]      sum_now;
  logic [CNT_W-1:0] cnt_now;

  fpadder u_add (
    .a   (acc_q),
    .b   (bus.in_data),
    .sub (bus.in_sub),
    .s   (add_s)
  );

  assign accept   = bus.in_valid && ready_q;
  assign step_nan = (&add_s[14:10]) && (|add_s[9:0]);
  assign nan_now  = nan_q | step_nan;
  // A NaN anywhere in the frame pins the running sum to the canonical quiet NaN.
  assign sum_now  = nan_now ? 16'h7E00 : add_s;
  assign sat      = &count_q;
  assign cnt_now  = sat ? count_q : count_q + CNT_W'(1);
  assign ovf_now  = ovf_q | sat;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    nan_d   = nan_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    ocnt_d  = ocnt_q;
    onan_d  = onan_q;
    oinf_d  = oinf_q;
    oovf_d  = oovf_q;
    case (state_q)
      S_IDLE, S_ACC: begin
        if (accept) begin
          acc_d   = sum_now;
          count_d = cnt_now;
          nan_d   = nan_now;
          ovf_d   = ovf_now;
          if (bus.in_last) begin
            state_d = S_DONE;
            sum_d   = sum_now;
            ocnt_d  = cnt_now;
            onan_d  = nan_now;
            oinf_d  = (&sum_now[14:10]) && !(|sum_now[9:0]);
            oovf_d  = ovf_now;
          end else begin
            state_d = S_ACC;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
          acc_d   = 16'h0000;
          count_d = '0;
          nan_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered so that in_ready stays low while rst_n is asserted.
    ready_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= 16'h0000;
      count_q <= '0;
      nan_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      sum_q   <= 16'h0000;
      ocnt_q  <= '0;
      onan_q  <= 1'b0;
      oinf_q  <= 1'b0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      nan_q   <= nan_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      sum_q   <= sum_d;
      ocnt_q  <= ocnt_d;
      onan_q  <= onan_d;
      oinf_q  <= oinf_d;
      oovf_q  <= oovf_d;
    end
  end

  assign bus.in_ready    = ready_q;
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.out_sum     = sum_q;
  assign bus.out_count   = ocnt_q;
  assign bus.out_nan     = onan_q;
  assign bus.out_inf     = oinf_q;
  assign bus.out_len_ovf = oovf_q;
endmodule
